// File: rtl/game_pkg.sv
// game_pkg
//  Shared definitions for the brick-breaker game-state logic: FSM state
//  encoding, default playfield geometry, block grid constants and a small
//  popcount helper used for scoring.
package game_pkg;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_WIN   = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam int GAME_SCREEN_W = 640;
  localparam int GAME_SCREEN_H = 480;

  // Block grid: 3 rows of 5 blocks, numbered 1..15 (bit i = block i+1).
  localparam int BLOCK_COLS = 5;
  localparam int BLOCK_ROWS = 3;
  localparam int NUM_BLOCKS = BLOCK_COLS * BLOCK_ROWS;

  // The collision stage lags the ball move by this many cycles, so flags
  // arriving right after a tick still describe the previous position.
  localparam int BLANK_CYCLES = 2;

  function automatic logic [3:0] popcount15(input logic [NUM_BLOCKS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/ball_block_ctrl_hit_accumulator.sv
// hit_accumulator
//  Sticky OR-latch for the registered collision flags between frame ticks.
//  The latch clears on the tick cycle (a flag on that cycle is dropped) and
//  then ignores inputs for BLANK_CYCLES cycles while the collision pipeline
//  catches up with the freshly moved ball.
// Ports
//  clk, rst         clock, synchronous active-low reset
//  frame_tick       one-cycle frame pulse
//  collide_paddle   paddle collision flag
//  collide_blocks   block collision flags
//  pending_paddle   accumulated paddle hit since last tick
//  pending_blocks   accumulated block hits since last tick
module hit_accumulator
  import game_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic                  collide_paddle,
  input  logic [NUM_BLOCKS-1:0] collide_blocks,
  output logic                  pending_paddle,
  output logic [NUM_BLOCKS-1:0] pending_blocks
);

  logic [1:0]            blank_reg;
  logic                  pend_paddle_reg;
  logic [NUM_BLOCKS-1:0] pend_blocks_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      blank_reg       <= '0;
      pend_paddle_reg <= 1'b0;
      pend_blocks_reg <= '0;
    end else if (frame_tick) begin
      blank_reg       <= 2'(BLANK_CYCLES);
      pend_paddle_reg <= 1'b0;
      pend_blocks_reg <= '0;
    end else if (blank_reg != 2'd0) begin
      blank_reg <= blank_reg - 2'd1;
    end else begin
      pend_paddle_reg <= pend_paddle_reg | collide_paddle;
      pend_blocks_reg <= pend_blocks_reg | collide_blocks;
    end
  end

  assign pending_paddle = pend_paddle_reg;
  assign pending_blocks = pend_blocks_reg;

endmodule

// File: rtl/ball_block_ctrl.sv
// ball_block_ctrl
//  Game-state owner for the brick breaker. Once per frame tick it moves the
//  ball, reflects velocity on wall/paddle/block hits, clears destroyed
//  blocks, keeps score and lives, and runs the SERVE/PLAY/WIN/OVER FSM.
// Ports
//  clk, rst                 clock, synchronous active-low reset
//  frame_tick               one-cycle pulse per video frame
//  launch                   serve/restart button (rising edge used)
//  paddle_x, paddle_width   paddle geometry
//  collide_paddle           registered paddle collision flag
//  collide_blocks           registered block collision flags
//  ball_x, ball_y           ball top-left position
//  ball_width, ball_height  constant ball size
//  alive                    block alive mask
//  score                    blocks destroyed this game (saturating)
//  lives                    remaining lives
//  game_state               0 SERVE, 1 PLAY, 2 WIN, 3 OVER
module ball_block_ctrl
  import game_pkg::*;
#(
  parameter int SCREEN_W     = GAME_SCREEN_W,
  parameter int SCREEN_H     = GAME_SCREEN_H,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_START_Y = 400,
  parameter int SPEED        = 2,
  parameter int NUM_LIVES    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic                  launch,
  input  logic [9:0]            paddle_x,
  input  logic [9:0]            paddle_width,
  input  logic                  collide_paddle,
  input  logic [NUM_BLOCKS-1:0] collide_blocks,
  output logic [9:0]            ball_x,
  output logic [9:0]            ball_y,
  output logic [9:0]            ball_width,
  output logic [9:0]            ball_height,
  output logic [NUM_BLOCKS-1:0] alive,
  output logic [7:0]            score,
  output logic [1:0]            lives,
  output logic [1:0]            game_state
);

  // 11-bit constants so position arithmetic never wraps.
  localparam logic [10:0] SCREEN_W_W = 11'(SCREEN_W);
  localparam logic [10:0] SCREEN_H_W = 11'(SCREEN_H);
  localparam logic [10:0] BALL_W     = 11'(BALL_SIZE);
  localparam logic [10:0] HALF_BALL  = 11'(BALL_SIZE / 2);
  localparam logic [10:0] SPEED_W    = 11'(SPEED);
  localparam logic [10:0] MAX_X      = 11'(SCREEN_W - BALL_SIZE);
  localparam logic [9:0]  START_X    = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [9:0]  START_Y    = 10'(BALL_START_Y);
  localparam logic [1:0]  LIVES_INIT = 2'(NUM_LIVES);
  localparam logic [NUM_BLOCKS-1:0] ALL_ALIVE = '1;

  game_state_t           state_reg;
  logic [9:0]            ball_x_reg, ball_y_reg;
  logic                  dx_reg;  // 1 = moving right
  logic                  dy_reg;  // 1 = moving down
  logic [NUM_BLOCKS-1:0] alive_reg;
  logic [7:0]            score_reg;
  logic [1:0]            lives_reg;
  logic                  launch_reg;

  logic                  pending_paddle;
  logic [NUM_BLOCKS-1:0] pending_blocks;

  hit_accumulator u_hit_accumulator (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .collide_paddle (collide_paddle),
    .collide_blocks (collide_blocks),
    .pending_paddle (pending_paddle),
    .pending_blocks (pending_blocks)
  );

  logic launch_rise;
  assign launch_rise = launch & ~launch_reg;

  // Ball centred on the paddle while serving, kept inside the playfield.
  logic [10:0] serve_sum;
  logic [9:0]  serve_x;
  always_comb begin
    serve_sum = {1'b0, paddle_x} + 11'(paddle_width >> 1);
    if (serve_sum < HALF_BALL) begin
      serve_x = '0;
    end else if (serve_sum - HALF_BALL > MAX_X) begin
      serve_x = MAX_X[9:0];
    end else begin
      serve_x = 10'(serve_sum - HALF_BALL);
    end
  end

  // PLAY-tick update, all derived from pre-tick register values.
  logic [NUM_BLOCKS-1:0] hits, alive_next;
  logic [8:0]            score_sum;
  logic [7:0]            score_next;
  logic                  dy_blk, dy_pad, dy_next, dx_next;
  logic [10:0]           x_ext, y_ext, x_next, y_next;
  logic                  floor_hit;

  always_comb begin
    hits       = pending_blocks & alive_reg;
    alive_next = alive_reg & ~hits;
    score_sum  = {1'b0, score_reg} + {5'b00000, popcount15(hits)};
    score_next = score_sum[8] ? 8'hFF : score_sum[7:0];

    // Any number of block hits reflects dy once; the paddle only turns a
    // descending ball upward.
    dy_blk = dy_reg ^ (|hits);
    dy_pad = (pending_paddle && dy_blk) ? 1'b0 : dy_blk;

    x_ext   = {1'b0, ball_x_reg};
    y_ext   = {1'b0, ball_y_reg};
    dx_next = dx_reg;
    if (!dx_reg) begin
      if (x_ext < SPEED_W) begin
        x_next  = '0;
        dx_next = 1'b1;
      end else begin
        x_next = x_ext - SPEED_W;
      end
    end else if (x_ext + BALL_W + SPEED_W > SCREEN_W_W) begin
      x_next  = MAX_X;
      dx_next = 1'b0;
    end else begin
      x_next = x_ext + SPEED_W;
    end

    dy_next = dy_pad;
    if (!dy_pad) begin
      if (y_ext < SPEED_W) begin
        y_next  = '0;
        dy_next = 1'b1;
      end else begin
        y_next = y_ext - SPEED_W;
      end
    end else begin
      y_next = y_ext + SPEED_W;
    end

    floor_hit = (y_next + BALL_W) >= SCREEN_H_W;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= ST_SERVE;
      ball_x_reg <= START_X;
      ball_y_reg <= START_Y;
      dx_reg     <= 1'b1;
      dy_reg     <= 1'b0;
      alive_reg  <= ALL_ALIVE;
      score_reg  <= '0;
      lives_reg  <= LIVES_INIT;
      launch_reg <= 1'b0;
    end else begin
      launch_reg <= launch;
      case (state_reg)
        ST_SERVE: begin
          if (frame_tick) begin
            ball_x_reg <= serve_x;
            ball_y_reg <= START_Y;
          end
          if (launch_rise) begin
            state_reg <= ST_PLAY;
            dx_reg    <= 1'b1;
            dy_reg    <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (frame_tick) begin
            alive_reg  <= alive_next;
            score_reg  <= score_next;
            dx_reg     <= dx_next;
            dy_reg     <= dy_next;
            ball_x_reg <= x_next[9:0];
            ball_y_reg <= y_next[9:0];
            // Clearing the last block wins even if the ball also hit the floor.
            if (alive_next == '0) begin
              state_reg <= ST_WIN;
            end else if (floor_hit) begin
              lives_reg <= lives_reg - 2'd1;
              state_reg <= (lives_reg == 2'd1) ? ST_OVER : ST_SERVE;
            end
          end
        end
        default: begin  // ST_WIN, ST_OVER: ball frozen until restart
          if (launch_rise) begin
            state_reg <= ST_SERVE;
            alive_reg <= ALL_ALIVE;
            score_reg <= '0;
            lives_reg <= LIVES_INIT;
            dx_reg    <= 1'b1;
            dy_reg    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ball_x      = ball_x_reg;
  assign ball_y      = ball_y_reg;
  assign ball_width  = BALL_W[9:0];
  assign ball_height = BALL_W[9:0];
  assign alive       = alive_reg;
  assign score       = score_reg;
  assign lives       = lives_reg;
  assign game_state  = state_reg;

endmodule
